// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cam_pkg
// Description : Shared constants and types for the OV7670 capture path.
//               Provides the camera FIFO word format, the frame-start marker
//               and the capture state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cam_pkg;

    // Width of one camera FIFO word: bit 16 flags a marker, [15:0] is a pixel.
    localparam int CAM_WORD_W = 17;

    // Written once at the start of every frame so the reader can resynchronise.
    localparam logic [CAM_WORD_W-1:0] FRAME_START_WORD = 17'h10000;

    // Default VGA frame geometry.
    localparam int DEFAULT_FRAME_WIDTH  = 640;
    localparam int DEFAULT_FRAME_HEIGHT = 480;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VBLANK = 2'd1,
        ACTIVE = 2'd2,
        DROP   = 2'd3
    } cam_state_t;

endpackage : cam_pkg
`default_nettype wire

// File: rtl/cam_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : cam_edge_detect
// Description : Registers the previous value of a sampled input and produces
//               single-cycle rise / fall pulses relative to the current input.
// Ports       : clk    - sampling clock
//               rst    - asynchronous active-high reset
//               i_din  - input level being monitored
//               o_rise - high when i_din is 1 and was 0 on the previous clock
//               o_fall - high when i_din is 0 and was 1 on the previous clock
// Revision    : 1.0 - initial release
// ============================================================================
module cam_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_rise,
    output logic o_fall
);

    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_din;
        end
    end

    assign o_rise = i_din & ~r_prev;
    assign o_fall = ~i_din & r_prev;

endmodule : cam_edge_detect
`default_nettype wire

// File: rtl/ov7670_pixel_packer.sv
`default_nettype none
// ============================================================================
// Module      : ov7670_pixel_packer
// Description : Samples the OV7670 parallel bus, packs byte pairs into RGB565
//               pixels and writes them to the camera FIFO, preceded by a
//               frame-start marker. Frames that overflow the FIFO or have a
//               malformed line structure are dropped from the first fault
//               until the next vertical sync.
// Ports       : clk          - camera pixel clock
//               reset        - asynchronous active-high reset
//               vsync        - vertical sync, high during blanking
//               href         - line valid
//               cam_data     - camera byte bus
//               fifo_full    - camera FIFO full flag
//               fifo_data    - FIFO write word (marker or {1'b0, pixel})
//               fifo_wr_en   - FIFO write strobe
//               frame_done   - one-cycle pulse after a clean frame
//               overflow_err - sticky FIFO overflow flag for this frame
//               line_err     - sticky line structure error for this frame
// Revision    : 1.0 - initial release
// ============================================================================
module ov7670_pixel_packer
    import cam_pkg::*;
#(
    parameter int FRAME_WIDTH  = DEFAULT_FRAME_WIDTH,
    parameter int FRAME_HEIGHT = DEFAULT_FRAME_HEIGHT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vsync,
    input  logic                  href,
    input  logic [7:0]            cam_data,
    input  logic                  fifo_full,
    output logic [CAM_WORD_W-1:0] fifo_data,
    output logic                  fifo_wr_en,
    output logic                  frame_done,
    output logic                  overflow_err,
    output logic                  line_err
);

    // Counters are one count wider than needed to index the frame so the
    // full value itself is representable and overruns can be compared.
    localparam int c_col_w  = $clog2(FRAME_WIDTH + 1);
    localparam int c_line_w = $clog2(FRAME_HEIGHT + 1);
    localparam logic [c_col_w-1:0]  c_width  = c_col_w'(FRAME_WIDTH);
    localparam logic [c_line_w-1:0] c_height = c_line_w'(FRAME_HEIGHT);

    // Edge pulses
    logic w_vsync_rise;
    logic w_vsync_fall;
    logic w_unused_href_rise;
    logic w_href_fall;

    cam_edge_detect u_vsync_edge (
        .clk    (clk),
        .rst    (reset),
        .i_din  (vsync),
        .o_rise (w_vsync_rise),
        .o_fall (w_vsync_fall)
    );

    cam_edge_detect u_href_edge (
        .clk    (clk),
        .rst    (reset),
        .i_din  (href),
        .o_rise (w_unused_href_rise),
        .o_fall (w_href_fall)
    );

    // State and datapath registers
    cam_state_t            r_state;
    logic [c_col_w-1:0]    r_col;
    logic [c_line_w-1:0]   r_line;
    logic                  r_phase;
    logic [7:0]            r_hi;
    logic [CAM_WORD_W-1:0] r_fifo_data;
    logic                  r_fifo_wr_en;
    logic                  r_frame_done;
    logic                  r_overflow_err;
    logic                  r_line_err;

    // Next-state values
    cam_state_t            w_state_nxt;
    logic [c_col_w-1:0]    w_col_nxt;
    logic [c_line_w-1:0]   w_line_nxt;
    logic                  w_phase_nxt;
    logic [7:0]            w_hi_nxt;
    logic [CAM_WORD_W-1:0] w_data_nxt;
    logic                  w_wr_nxt;
    logic                  w_done_nxt;
    logic                  w_ovf_nxt;
    logic                  w_lerr_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_line_nxt  = r_line;
        w_phase_nxt = r_phase;
        w_hi_nxt    = r_hi;
        w_data_nxt  = r_fifo_data;
        w_wr_nxt    = 1'b0;
        w_done_nxt  = 1'b0;
        w_ovf_nxt   = r_overflow_err;
        w_lerr_nxt  = r_line_err;

        case (r_state)
            IDLE: begin
                // Only a full blanking interval is a safe place to start.
                if (vsync) begin
                    w_state_nxt = VBLANK;
                end
            end

            VBLANK: begin
                if (w_vsync_fall) begin
                    w_ovf_nxt   = 1'b0;
                    w_lerr_nxt  = 1'b0;
                    w_col_nxt   = '0;
                    w_line_nxt  = '0;
                    w_phase_nxt = 1'b0;
                    if (fifo_full) begin
                        w_ovf_nxt   = 1'b1;
                        w_state_nxt = DROP;
                    end else begin
                        w_wr_nxt    = 1'b1;
                        w_data_nxt  = FRAME_START_WORD;
                        w_state_nxt = ACTIVE;
                        // A first byte arriving with the marker is kept.
                        if (href) begin
                            w_hi_nxt    = cam_data;
                            w_phase_nxt = 1'b1;
                        end
                    end
                end
            end

            ACTIVE: begin
                if (w_vsync_rise) begin
                    w_state_nxt = VBLANK;
                    if (r_line == c_height) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_lerr_nxt = 1'b1;
                    end
                end else if (href) begin
                    if (r_line == c_height) begin
                        // Data beyond the last expected line.
                        w_lerr_nxt  = 1'b1;
                        w_state_nxt = DROP;
                    end else if (!r_phase) begin
                        w_hi_nxt    = cam_data;
                        w_phase_nxt = 1'b1;
                    end else if (r_col == c_width) begin
                        // More pixels than a line may hold.
                        w_lerr_nxt  = 1'b1;
                        w_state_nxt = DROP;
                    end else if (fifo_full) begin
                        w_ovf_nxt   = 1'b1;
                        w_state_nxt = DROP;
                    end else begin
                        w_wr_nxt    = 1'b1;
                        w_data_nxt  = {1'b0, r_hi, cam_data};
                        w_col_nxt   = r_col + c_col_w'(1);
                        w_phase_nxt = 1'b0;
                    end
                end else if (w_href_fall) begin
                    if (r_phase || (r_col != c_width)) begin
                        w_lerr_nxt  = 1'b1;
                        w_state_nxt = DROP;
                    end else begin
                        w_line_nxt = r_line + c_line_w'(1);
                        w_col_nxt  = '0;
                    end
                end
            end

            DROP: begin
                if (vsync) begin
                    w_state_nxt = VBLANK;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col          <= '0;
            r_line         <= '0;
            r_phase        <= 1'b0;
            r_hi           <= 8'h00;
            r_fifo_data    <= '0;
            r_fifo_wr_en   <= 1'b0;
            r_frame_done   <= 1'b0;
            r_overflow_err <= 1'b0;
            r_line_err     <= 1'b0;
        end else begin
            r_col          <= w_col_nxt;
            r_line         <= w_line_nxt;
            r_phase        <= w_phase_nxt;
            r_hi           <= w_hi_nxt;
            r_fifo_data    <= w_data_nxt;
            r_fifo_wr_en   <= w_wr_nxt;
            r_frame_done   <= w_done_nxt;
            r_overflow_err <= w_ovf_nxt;
            r_line_err     <= w_lerr_nxt;
        end
    end

    assign fifo_data    = r_fifo_data;
    assign fifo_wr_en   = r_fifo_wr_en;
    assign frame_done   = r_frame_done;
    assign overflow_err = r_overflow_err;
    assign line_err     = r_line_err;

endmodule : ov7670_pixel_packer
`default_nettype wire

// File: tb/tb_ov7670_pixel_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ov7670_pixel_packer
// Description : Self-checking bench for ov7670_pixel_packer with a 4x2 frame.
//               A frame-level model predicts the FIFO word stream and flags;
//               a negedge monitor compares every written word in order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ov7670_pixel_packer;

    localparam int W = 4;
    localparam int H = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic [7:0]  cam_data = 8'h00;
    logic        fifo_full = 1'b0;
    logic [16:0] fifo_data;
    logic        fifo_wr_en;
    logic        frame_done;
    logic        overflow_err;
    logic        line_err;

    ov7670_pixel_packer #(
        .FRAME_WIDTH  (W),
        .FRAME_HEIGHT (H)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .vsync        (vsync),
        .href         (href),
        .cam_data     (cam_data),
        .fifo_full    (fifo_full),
        .fifo_data    (fifo_data),
        .fifo_wr_en   (fifo_wr_en),
        .frame_done   (frame_done),
        .overflow_err (overflow_err),
        .line_err     (line_err)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    int          done_cnt = 0;
    int          wr_cnt = 0;
    logic [16:0] exp_q[$];
    logic [16:0] wlog[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Word-stream monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_done) done_cnt++;
            if (fifo_wr_en) begin
                wr_cnt++;
                wlog.push_back(fifo_data);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_write: got %0h expected no write", fifo_data);
                end else begin
                    check("fifo_word", 32'(fifo_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    function automatic logic [7:0] bval(input int k);
        return 8'(32'h12 + 32'h22 * k);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame of nl lines (byte counts b0..b2). full_idx selects the
    // write attempt that sees fifo_full: 0 = marker, n = n-th pixel, -1 = none.
    task automatic run_frame(input int nl, input int b0, input int b1, input int b2,
                             input int full_idx);
        int nb[3];
        int k, pc, col;
        logic [7:0] hi, bt;
        logic e_ovf, e_lerr, e_done, stop;
        nb = '{b0, b1, b2};

        // Model
        e_ovf = 1'b0; e_lerr = 1'b0; e_done = 1'b0; stop = 1'b0;
        k = 0; pc = 0; hi = 8'h00;
        if (full_idx == 0) begin
            e_ovf = 1'b1;
            stop  = 1'b1;
        end else begin
            exp_q.push_back(17'h10000);
        end
        for (int l = 0; l < nl; l++) begin
            if (!stop && l >= H && nb[l] > 0) begin
                e_lerr = 1'b1;
                stop   = 1'b1;
            end
            col = 0;
            for (int b = 0; b < nb[l]; b++) begin
                bt = bval(k);
                k++;
                if (b % 2 == 0) begin
                    hi = bt;
                end else begin
                    pc++;
                    col++;
                    if (!stop) begin
                        if (col > W) begin
                            e_lerr = 1'b1;
                            stop   = 1'b1;
                        end else if (pc == full_idx) begin
                            e_ovf = 1'b1;
                            stop  = 1'b1;
                        end else begin
                            exp_q.push_back({1'b0, hi, bt});
                        end
                    end
                end
            end
            if (!stop && ((nb[l] % 2) != 0 || col != W)) begin
                e_lerr = 1'b1;
                stop   = 1'b1;
            end
        end
        if (!stop) begin
            if (nl == H) e_done = 1'b1;
            else         e_lerr = 1'b1;
        end

        // Drive
        done_cnt = 0;
        vsync = 1'b1;
        href  = 1'b0;
        repeat (3) tick();
        vsync     = 1'b0;
        fifo_full = (full_idx == 0);
        tick();
        fifo_full = 1'b0;
        check("marker_wr_en", 32'(fifo_wr_en), 32'(full_idx != 0));
        if (full_idx != 0) check("marker_word", 32'(fifo_data), 32'h10000);
        tick();
        k = 0; pc = 0;
        for (int l = 0; l < nl; l++) begin
            for (int b = 0; b < nb[l]; b++) begin
                href     = 1'b1;
                cam_data = bval(k);
                k++;
                if (b % 2 == 1) pc++;
                fifo_full = (b % 2 == 1) && (pc == full_idx);
                tick();
            end
            href      = 1'b0;
            fifo_full = 1'b0;
            repeat (3) tick();
        end
        vsync = 1'b1;
        repeat (3) tick();

        check("words_drained", 32'(exp_q.size()), 32'd0);
        check("frame_done_cnt", 32'(done_cnt), 32'(e_done));
        check("overflow_err", 32'(overflow_err), 32'(e_ovf));
        check("line_err", 32'(line_err), 32'(e_lerr));
    endtask

    initial begin
        int wr_snap;

        // Reset values
        repeat (3) tick();
        check("rst_fifo_data", 32'(fifo_data), 32'h0);
        check("rst_fifo_wr_en", 32'(fifo_wr_en), 32'h0);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        check("rst_overflow_err", 32'(overflow_err), 32'h0);
        check("rst_line_err", 32'(line_err), 32'h0);
        reset = 1'b0;
        repeat (2) tick();

        // Clean frame with literal pins on the model
        wlog.delete();
        run_frame(2, 8, 8, 0, -1);
        check("log_size", 32'(wlog.size()), 32'd9);
        if (wlog.size() == 9) begin
            check("log0_marker", 32'(wlog[0]), 32'h10000);
            check("log1_pixel", 32'(wlog[1]), 32'h01234);
            check("log4_pixel", 32'(wlog[4]), 32'h0de00);
            check("log8_pixel", 32'(wlog[8]), 32'h0ee10);
        end

        // FIFO full on the third pixel write
        wlog.delete();
        run_frame(2, 8, 8, 0, 3);
        check("ovf_log_size", 32'(wlog.size()), 32'd3);
        run_frame(2, 8, 8, 0, -1);

        // Odd byte count on the first line
        run_frame(2, 7, 8, 0, -1);
        run_frame(2, 8, 8, 0, -1);

        // Too few lines
        run_frame(1, 8, 0, 0, -1);

        // Reset during an active frame, released with vsync low and href toggling
        vsync = 1'b1;
        repeat (3) tick();
        exp_q.push_back(17'h10000);
        vsync = 1'b0;
        tick();
        tick();
        href     = 1'b1;
        cam_data = 8'hA5;
        tick();
        reset = 1'b1;
        check("pre_reset_drained", 32'(exp_q.size()), 32'd0);
        cam_data = 8'h5A;
        tick();
        tick();
        wr_snap = wr_cnt;
        reset   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            href     = (i % 4) < 2;
            cam_data = 8'(i * 17);
            tick();
        end
        href = 1'b0;
        repeat (3) tick();
        check("no_write_after_reset", 32'(wr_cnt - wr_snap), 32'd0);
        check("reset_clears_line_err", 32'(line_err), 32'd0);
        wlog.delete();
        run_frame(2, 8, 8, 0, -1);
        check("post_reset_first_word", 32'((wlog.size() > 0) ? wlog[0] : 17'h0), 32'h10000);

        // FIFO full at frame start
        wlog.delete();
        run_frame(2, 8, 8, 0, 0);
        check("full_marker_no_words", 32'(wlog.size()), 32'd0);
        run_frame(2, 8, 8, 0, -1);

        // Extra line beyond the frame height
        run_frame(3, 8, 8, 8, -1);
        run_frame(2, 8, 8, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_ov7670_pixel_packer
`default_nettype wire
